// File: rtl/alu_cmd_queue_if.sv
// Command/result handshake bundle between the source/consumer and the ALU command queue.
interface alu_cmd_queue_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_carry;
  logic             out_overflow;
  logic             out_illegal;

  // Source/consumer side: issues commands, accepts results.
  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carry, out_overflow, out_illegal
  );

  // Queue side: accepts commands, presents results.
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carry, out_overflow, out_illegal
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of an external combinational ALU with a registered result stage.
module alu_cmd_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OPW   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  alu_cmd_queue_if.slave               bus,
  output logic [OPW-1:0]               alu_opcode,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  input  logic [WIDTH-1:0]             alu_result,
  input  logic                         alu_zero,
  input  logic                         alu_carry_out,
  input  logic                         alu_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PTRW       = $clog2(DEPTH);
  localparam int unsigned LVLW       = $clog2(DEPTH + 1);
  localparam int unsigned ILLEGAL_OP = 24;

  typedef struct packed {
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [LVLW-1:0]  count;
  logic             rst_done;

  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_carry;
  logic             out_overflow;
  logic             out_illegal;

  logic             full;
  logic             empty;
  logic             in_ready;
  logic             out_free;
  logic             push;
  logic             pop;
  cmd_t             head;
  cmd_t             cmd_in;

  assign full     = (count == LVLW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = rst_done & ~full & ~flush;
  assign out_free = ~out_valid | bus.out_ready;
  assign push     = bus.in_valid & in_ready;
  assign pop      = ~empty & out_free & ~flush;
  assign head     = mem[rd_ptr];
  assign cmd_in   = '{opcode: bus.in_opcode, a: bus.in_a, b: bus.in_b};

  // Head entry drives the ALU; gated to zero so an empty queue presents a clean operand set.
  assign alu_opcode = empty ? '0 : head.opcode;
  assign alu_a      = empty ? '0 : head.a;
  assign alu_b      = empty ? '0 : head.b;

  assign level            = count;
  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_result   = out_result;
  assign bus.out_zero     = out_zero;
  assign bus.out_carry    = out_carry;
  assign bus.out_overflow = out_overflow;
  assign bus.out_illegal  = out_illegal;

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + LVLW'(1);
        2'b01:   count <= count - LVLW'(1);
        default: count <= count;
      endcase
    end
  end

  // Command storage; payload only, so no reset needed (head is gated when empty).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // Result stage: capture ALU result and flags together on pop, otherwise hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid    <= 1'b1;
      out_result   <= alu_result;
      out_zero     <= alu_zero;
      out_carry    <= alu_carry_out;
      out_overflow <= alu_overflow;
      out_illegal  <= (head.opcode >= OPW'(ILLEGAL_OP));
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
